rf_write_sched: RTL and testbench
=================================

// Module: rf_write_sched
// PURPOSE
//  Schedules the single register-file write port between two producers: the ALU writeback
//  (no back-pressure, priority) and the memory-load return (queued, valid/ready).
//  Loads wait in a small FIFO; a starvation limiter forces a drain; WAW hazards are resolved.
//  Sits between execute/memory stages and reg_file's write inputs (we/addr/data).
// PARAMETERS
//  W          8  data width of a register
//  D          3  register address width (2**D registers)
//  DEPTH      4  load FIFO entries (power of 2, >=2)
//  STARVE_LIM 4  consecutive cycles a non-empty FIFO may lose to the ALU before forced drain
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  alu_wr_valid in   1       ALU writeback request this cycle
//  alu_wr_addr  in   D       ALU destination register
//  alu_wr_data  in   W       ALU result
//  ld_wr_valid  in   1       load return valid
//  ld_wr_addr   in   D       load destination register
//  ld_wr_data   in   W       load data
//  ld_wr_ready  out  1       FIFO can accept (count < DEPTH)
//  rf_we        out  1       registered write enable to reg file
//  rf_waddr     out  D       registered write address
//  rf_wdata     out  W       registered write data
//  stall        out  1       ALU must not present alu_wr_valid this cycle
//  pending_mask out  2**D    bit r set if an unsquashed FIFO entry targets register r
//  err          out  1       sticky: alu_wr_valid seen while stall=1
//  stat_alu/stat_ld/stat_sq out 16 each  grant/squash counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FIFO empty, state NORMAL, starve cnt 0; rf_we=0, rf_waddr=0, rf_wdata=0,
//   ld_wr_ready=1, stall=0, pending_mask=0, err=0, stats=0.
//  Enqueue when ld_wr_valid&&ld_wr_ready; entry = {addr,data,live=1}. ld_wr_ready derives
//   from registered count only (no same-cycle pop credit).
//  State NORMAL (stall=0): alu_wr_valid -> ALU granted; else FIFO non-empty -> pop head.
//  State FORCE (stall=1): pop head; any alu_wr_valid is dropped and sets err. FORCE lasts
//   exactly one cycle, then NORMAL, starve cnt cleared.
//  Starve cnt: +1 each cycle ALU granted while FIFO non-empty; cleared on any pop or when
//   FIFO empty. NORMAL->FORCE at the edge where cnt reaches STARVE_LIM.
//  Grant -> rf_we/rf_waddr/rf_wdata registered: 1-cycle latency from request.
//   Load minimum latency 2 cycles (enqueue cycle, pop cycle, then port).
//  Popping a squashed entry (live=0) frees the slot, rf_we=0 that cycle, counts as pop.
//  No grant: rf_we=0; rf_waddr/rf_wdata hold previous values.
//  WAW: ALU write granted to addr X clears live on every FIFO entry with addr X already
//   stored; a load to X enqueued in the same cycle is younger and stays live.
//  pending_mask: combinational OR over live entries; drives upstream read-hazard stall.
//  Empty FIFO in FORCE impossible (cnt cleared when empty). Full FIFO: ld_wr_ready=0.
//  Pointers wrap modulo DEPTH; count is D_cnt=$clog2(DEPTH)+1 bits.
//  Reset mid-operation discards all queued loads; no rf_we issued for them.
// CONFIGURATION
//  RF_WRITE_SCHED_STATS_EN defined: stat_alu += each ALU grant, stat_ld += each live pop,
//   stat_sq += each squash-clear of an entry; all 16-bit saturating at 16'hFFFF.
//  Not defined: counters not built, stat_* tied to 0.
// TESTING
//  1 Load only: ld addr=3 data=8'h5A at t0 -> rf_we=1,addr=3,data=8'h5A at t0+2; ready stays 1.
//  2 Fill: 4 loads with alu_wr_valid held 1 -> ld_wr_ready=0 after 4th; no 5th accepted.
//  3 Starvation (LIM=4): ALU valid every cycle, 1 load queued -> stall=1 on 5th cycle,
//    load written next cycle, stall=0 after; ALU valid during stall -> err=1, write dropped.
//  4 WAW: load r2=8'h11 queued, ALU r2=8'h22 granted -> pending_mask[2] clears, only
//    8'h22 written to r2; same-cycle load r2 + ALU r2 -> ALU then load (load wins).
//  5 Reset asserted with 3 queued loads -> all outputs to reset values asynchronously,
//    no rf_we after release.
//  6 STATS_EN: scenario 4 -> stat_alu=1, stat_ld=0, stat_sq=1; saturate at 16'hFFFF.

Source files
------------

// File: rtl/rf_write_sched.sv
// +------------------------------------------------------------------------+
// | rf_write_sched: arbitrates the register-file write port between the    |
// | ALU writeback and a queued load return, with WAW squash and a          |
// | starvation-forced drain. Optional counters: RF_WRITE_SCHED_STATS_EN.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rf_write_sched #(
  parameter int W          = 8,
  parameter int D          = 3,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wr_valid,
  input  logic [D-1:0]      alu_wr_addr,
  input  logic [W-1:0]      alu_wr_data,
  input  logic              ld_wr_valid,
  input  logic [D-1:0]      ld_wr_addr,
  input  logic [W-1:0]      ld_wr_data,
  output logic              ld_wr_ready,
  output logic              rf_we,
  output logic [D-1:0]      rf_waddr,
  output logic [W-1:0]      rf_wdata,
  output logic              stall,
  output logic [(1<<D)-1:0] pending_mask,
  output logic              err,
  output logic [15:0]       stat_alu,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_sq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [D-1:0]    addr_mem_q [DEPTH];
  logic [D-1:0]    addr_mem_d [DEPTH];
  logic [W-1:0]    data_mem_q [DEPTH];
  logic [W-1:0]    data_mem_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic            rf_we_q, rf_we_d;
  logic [D-1:0]    rf_waddr_q, rf_waddr_d;
  logic [W-1:0]    rf_wdata_q, rf_wdata_d;
  logic            err_q, err_d;

  logic            non_empty, push, pop, grant_alu, head_live;
  logic [DEPTH-1:0] squash_mask;

  assign non_empty   = (count_q != '0);
  assign ld_wr_ready = (count_q < CW'(DEPTH));
  assign push        = ld_wr_valid && ld_wr_ready;
  assign grant_alu   = (state_q == ST_NORMAL) && alu_wr_valid;
  assign pop         = non_empty && ((state_q == ST_FORCE) || !alu_wr_valid);
  assign head_live   = live_q[rd_ptr_q];

  // live doubles as occupancy: a slot is cleared on pop as well as on squash
  always_comb begin
    squash_mask  = '0;
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_mask[i] = grant_alu && live_q[i] && (addr_mem_q[i] == alu_wr_addr);
      if (live_q[i]) pending_mask[addr_mem_q[i]] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    live_d     = live_q & ~squash_mask;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q | ((state_q == ST_FORCE) && alu_wr_valid);

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end
    // the enqueued load is younger than the ALU write, so it is set after the squash
    if (push) begin
      addr_mem_d[wr_ptr_q] = ld_wr_addr;
      data_mem_d[wr_ptr_q] = ld_wr_data;
      live_d[wr_ptr_q]     = 1'b1;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (grant_alu) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_wr_addr;
      rf_wdata_d = alu_wr_data;
    end else if (pop && head_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_mem_q[rd_ptr_q];
      rf_wdata_d = data_mem_q[rd_ptr_q];
    end

    if (!non_empty || pop)  starve_d = '0;
    else if (grant_alu)     starve_d = starve_q + SW'(1);

    if (state_q == ST_FORCE)                 state_d = ST_NORMAL;
    else if (starve_d == SW'(STARVE_LIM))    state_d = ST_FORCE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      starve_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      live_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      live_q     <= live_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign stall    = (state_q == ST_FORCE);
  assign err      = err_q;

`ifdef RF_WRITE_SCHED_STATS_EN
  logic [15:0]   stat_alu_q, stat_alu_d, stat_ld_q, stat_ld_d, stat_sq_q, stat_sq_d;
  logic [CW-1:0] sq_cnt;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    sq_cnt = '0;
    for (int i = 0; i < DEPTH; i++) sq_cnt = sq_cnt + CW'(squash_mask[i]);
    stat_alu_d = sat_add(stat_alu_q, CW'(grant_alu));
    stat_ld_d  = sat_add(stat_ld_q, CW'(pop && head_live));
    stat_sq_d  = sat_add(stat_sq_q, sq_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_alu_q <= '0;
      stat_ld_q  <= '0;
      stat_sq_q  <= '0;
    end else begin
      stat_alu_q <= stat_alu_d;
      stat_ld_q  <= stat_ld_d;
      stat_sq_q  <= stat_sq_d;
    end
  end

  assign stat_alu = stat_alu_q;
  assign stat_ld  = stat_ld_q;
  assign stat_sq  = stat_sq_q;
`else
  assign stat_alu = '0;
  assign stat_ld  = '0;
  assign stat_sq  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_write_sched.sv
// +------------------------------------------------------------------------+
// | tb_rf_write_sched: directed self-checking bench for rf_write_sched.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr_valid, ld_wr_valid;
  logic [2:0]  alu_wr_addr, ld_wr_addr;
  logic [7:0]  alu_wr_data, ld_wr_data;
  logic        ld_wr_ready, rf_we, stall, err;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  pending_mask;
  logic [15:0] stat_alu, stat_ld, stat_sq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_sched #(.W(8), .D(3), .DEPTH(4), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .ld_wr_valid(ld_wr_valid), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ld_wr_ready(ld_wr_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall(stall), .pending_mask(pending_mask), .err(err),
    .stat_alu(stat_alu), .stat_ld(stat_ld), .stat_sq(stat_sq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_wr_valid = 1'b0;
    ld_wr_valid  = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    alu_wr_addr = '0; alu_wr_data = '0; ld_wr_addr = '0; ld_wr_data = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks += 8;
    if (rf_we !== 1'b0)        begin n_fail++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    if (rf_waddr !== 3'd0)     begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    if (rf_wdata !== 8'h00)    begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", rf_wdata); end
    if (ld_wr_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ld_wr_ready); end
    if (stall !== 1'b0)        begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    if (pending_mask !== 8'h0) begin n_fail++; $display("FAIL reset_pending got=%h exp=00", pending_mask); end
    if (err !== 1'b0)          begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    if ({stat_alu, stat_ld, stat_sq} !== 48'd0)
      begin n_fail++; $display("FAIL reset_stats got=%h/%h/%h exp=0/0/0", stat_alu, stat_ld, stat_sq); end
    tick(); tick();
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_load_only;
    ld_wr_valid = 1'b1; ld_wr_addr = 3'd3; ld_wr_data = 8'h5A;
    tick();
    idle();
    n_checks += 3;
    if (rf_we !== 1'b0)         begin n_fail++; $display("FAIL ld_early_we got=%b exp=0", rf_we); end
    if (ld_wr_ready !== 1'b1)   begin n_fail++; $display("FAIL ld_ready got=%b exp=1", ld_wr_ready); end
    if (pending_mask !== 8'h08) begin n_fail++; $display("FAIL ld_pending got=%h exp=08", pending_mask); end
    tick();
    n_checks += 1;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 8'h5A})
      begin n_fail++; $display("FAIL ld_write got=%b/%0d/%h exp=1/3/5a", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_checks += 2;
    if ({rf_we, rf_wdata} !== {1'b0, 8'h5A})
      begin n_fail++; $display("FAIL ld_hold got=%b/%h exp=0/5a", rf_we, rf_wdata); end
    if (pending_mask !== 8'h00) begin n_fail++; $display("FAIL ld_pending_clr got=%h exp=00", pending_mask); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      alu_wr_valid = 1'b1; alu_wr_addr = 3'd7; alu_wr_data = 8'hA0 + 8'(i);
      ld_wr_valid  = 1'b1; ld_wr_addr  = 3'(i); ld_wr_data = 8'h10 + 8'(i);
      tick();
      n_checks += 2;
      if (ld_wr_ready !== (i < 3))
        begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, ld_wr_ready, (i < 3)); end
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd7, 8'hA0 + 8'(i)})
        begin n_fail++; $display("FAIL fill_alu[%0d] got=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata); end
    end
    n_checks += 1;
    if (pending_mask !== 8'h0F) begin n_fail++; $display("FAIL fill_pending got=%h exp=0f", pending_mask); end
    ld_wr_addr = 3'd5; ld_wr_data = 8'h99; alu_wr_data = 8'hA4;
    tick();
    idle();
    n_checks += 2;
    if ({ld_wr_ready, stall} !== 2'b01)
      begin n_fail++; $display("FAIL fill_force got=ready%b/stall%b exp=0/1", ld_wr_ready, stall); end
    if (rf_wdata !== 8'hA4) begin n_fail++; $display("FAIL fill_alu4 got=%h exp=a4", rf_wdata); end
    tick();
    n_checks += 2;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd0, 8'h10})
      begin n_fail++; $display("FAIL fill_pop0 got=%b/%0d/%h exp=1/0/10", rf_we, rf_waddr, rf_wdata); end
    if ({ld_wr_ready, stall} !== 2'b10)
      begin n_fail++; $display("FAIL fill_after got=ready%b/stall%b exp=1/0", ld_wr_ready, stall); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks += 1;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'(i), 8'h10 + 8'(i)})
        begin n_fail++; $display("FAIL fill_pop%0d got=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata); end
    end
    tick();
    n_checks += 2;
    if ({rf_we, pending_mask} !== {1'b0, 8'h00})
      begin n_fail++; $display("FAIL fill_no5th got=%b/%h exp=0/00", rf_we, pending_mask); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL fill_err got=%b exp=0", err); end
  endtask

  task automatic waw_first_half;
    ld_wr_valid = 1'b1; ld_wr_addr = 3'd2; ld_wr_data = 8'h11;
    tick();
    idle();
    n_checks += 1;
    if (pending_mask !== 8'h04) begin n_fail++; $display("FAIL waw_pend_set got=%h exp=04", pending_mask); end
    alu_wr_valid = 1'b1; alu_wr_addr = 3'd2; alu_wr_data = 8'h22;
    tick();
    idle();
    n_checks += 2;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd2, 8'h22})
      begin n_fail++; $display("FAIL waw_alu got=%b/%0d/%h exp=1/2/22", rf_we, rf_waddr, rf_wdata); end
    if (pending_mask !== 8'h00) begin n_fail++; $display("FAIL waw_pend_clr got=%h exp=00", pending_mask); end
    tick();
    n_checks += 1;
    if ({rf_we, rf_wdata} !== {1'b0, 8'h22})
      begin n_fail++; $display("FAIL waw_squashed got=%b/%h exp=0/22", rf_we, rf_wdata); end
  endtask

  task automatic test_waw;
    waw_first_half();
    ld_wr_valid  = 1'b1; ld_wr_addr  = 3'd2; ld_wr_data  = 8'h33;
    alu_wr_valid = 1'b1; alu_wr_addr = 3'd2; alu_wr_data = 8'h44;
    tick();
    idle();
    n_checks += 2;
    if ({rf_we, rf_wdata} !== {1'b1, 8'h44})
      begin n_fail++; $display("FAIL waw_same_alu got=%b/%h exp=1/44", rf_we, rf_wdata); end
    if (pending_mask !== 8'h04) begin n_fail++; $display("FAIL waw_same_pend got=%h exp=04", pending_mask); end
    tick();
    n_checks += 1;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd2, 8'h33})
      begin n_fail++; $display("FAIL waw_same_ld got=%b/%0d/%h exp=1/2/33", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_checks += 1;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL waw_end_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_starvation;
    alu_wr_valid = 1'b1; alu_wr_addr = 3'd6; alu_wr_data = 8'h60;
    ld_wr_valid  = 1'b1; ld_wr_addr  = 3'd1; ld_wr_data  = 8'h77;
    tick();
    ld_wr_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      n_checks += 1;
      if ({stall, rf_we, rf_wdata} !== {1'b0, 1'b1, 8'h60 + 8'(k - 1)})
        begin n_fail++; $display("FAIL starve_c%0d got=stall%b/%b/%h", k, stall, rf_we, rf_wdata); end
      alu_wr_data = 8'h60 + 8'(k);
      tick();
    end
    n_checks += 2;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall got=%b exp=1", stall); end
    if (pending_mask !== 8'h02) begin n_fail++; $display("FAIL starve_pend got=%h exp=02", pending_mask); end
    alu_wr_data = 8'hEE;
    tick();
    idle();
    n_checks += 2;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 8'h77})
      begin n_fail++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/1/77", rf_we, rf_waddr, rf_wdata); end
    if ({stall, err} !== 2'b01)
      begin n_fail++; $display("FAIL starve_err got=stall%b/err%b exp=0/1", stall, err); end
    tick();
    n_checks += 1;
    if ({rf_we, rf_wdata, err, stall} !== {1'b0, 8'h77, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL starve_dropped got=%b/%h/%b/%b exp=0/77/1/0", rf_we, rf_wdata, err, stall); end
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 3; i++) begin
      alu_wr_valid = 1'b1; alu_wr_addr = 3'd7; alu_wr_data = 8'h55;
      ld_wr_valid  = 1'b1; ld_wr_addr  = 3'(4 + i); ld_wr_data = 8'h40 + 8'(i);
      tick();
    end
    idle();
    n_checks += 1;
    if (pending_mask !== 8'h70) begin n_fail++; $display("FAIL mid_pend got=%h exp=70", pending_mask); end
    #2 reset = 1'b1;
    #1;
    n_checks += 2;
    if ({rf_we, rf_waddr, rf_wdata, pending_mask} !== {1'b0, 3'd0, 8'h00, 8'h00})
      begin n_fail++; $display("FAIL mid_async got=%b/%0d/%h/%h exp=0/0/00/00", rf_we, rf_waddr, rf_wdata, pending_mask); end
    if ({ld_wr_ready, stall, err} !== 3'b100)
      begin n_fail++; $display("FAIL mid_ctrl got=%b%b%b exp=100", ld_wr_ready, stall, err); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks += 1;
      if ({rf_we, pending_mask} !== {1'b0, 8'h00})
        begin n_fail++; $display("FAIL mid_after[%0d] got=%b/%h exp=0/00", c, rf_we, pending_mask); end
    end
  endtask

`ifdef RF_WRITE_SCHED_STATS_EN
  task automatic test_stats;
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    waw_first_half();
    n_checks += 1;
    if ({stat_alu, stat_ld, stat_sq} !== {16'd1, 16'd0, 16'd1})
      begin n_fail++; $display("FAIL stats_waw got=%0d/%0d/%0d exp=1/0/1", stat_alu, stat_ld, stat_sq); end
    alu_wr_valid = 1'b1; alu_wr_addr = 3'd0; alu_wr_data = 8'h00;
    for (int c = 0; c < 65540; c++) tick();
    idle();
    tick();
    n_checks += 1;
    if (stat_alu !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat got=%h exp=ffff", stat_alu); end
  endtask
`else
  task automatic test_stats;
    n_checks += 1;
    if ({stat_alu, stat_ld, stat_sq} !== 48'd0)
      begin n_fail++; $display("FAIL stats_off got=%h/%h/%h exp=0/0/0", stat_alu, stat_ld, stat_sq); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_only();
    test_fill();
    test_waw();
    test_starvation();
    test_reset_midop();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
